// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer, its register file and the ALU itself.
// No logic: opcode encodings, FSM state encoding, widths and the latched-instruction record.
// Backpressure: not applicable.
package alu_seq_pkg;

    localparam int REG_W    = 2;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 1 << REG_W;

    localparam logic [2:0] OP_INV = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_LDI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Fields of the accepted instruction that the ALU ports do not already carry.
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] imm;
    } instr_lat_t;

endpackage

// File: rtl/alu_regfile.sv
// 4x8 register file: two combinational operand reads, one combinational debug read.
// Latency: reads 0 cycles; a write is visible from the cycle after its edge.
// Backpressure: none, the write port is always accepted.
module alu_regfile
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [REG_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_W-1:0]  rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [REG_W-1:0]  rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [REG_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
    assign dbg_data  = regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Issues one instruction at a time to an external combinational ALU and writes the result back.
// Latency: accept -> EXEC -> WB, write at the end of WB; one instruction per 3 cycles.
// Backpressure: instr_ready is high only in IDLE; instr_valid while not ready is ignored.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [REG_W-1:0]  instr_rd,
    input  logic [REG_W-1:0]  instr_rs1,
    input  logic [REG_W-1:0]  instr_rs2,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    output logic [REG_W-1:0]  res_rd,
    output logic [DATA_W-1:0] res_data,
    input  logic [REG_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  retired
);

    state_t            state;
    state_t            next_state;
    instr_lat_t        lat;
    logic              accept;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;

    alu_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (res_valid),
        .wr_addr   (res_rd),
        .wr_data   (res_data),
        .rd_addr_a (instr_rs1),
        .rd_data_a (rs1_data),
        .rd_addr_b (instr_rs2),
        .rd_data_b (rs2_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        res_valid   = 1'b0;
        accept      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                accept      = instr_valid;
                if (instr_valid) begin
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: next_state = ST_WB;
            ST_WB: begin
                res_valid  = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // alu_opcode doubles as the latched opcode, so LDI is detected from it in EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            lat        <= '0;
            res_rd     <= '0;
            res_data   <= '0;
            retired    <= '0;
        end else begin
            if (accept) begin
                alu_a      <= rs1_data;
                alu_b      <= rs2_data;
                alu_opcode <= instr_op;
                lat.rd     <= instr_rd;
                lat.imm    <= instr_imm;
            end
            if (state == ST_EXEC) begin
                res_rd   <= lat.rd;
                res_data <= (alu_opcode == OP_LDI) ? lat.imm : alu_out;
            end
            if (res_valid) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU; a CNT_W=2 twin shares stimulus.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              instr_valid;
    logic              instr_ready, instr_ready2;
    logic [2:0]        instr_op;
    logic [REG_W-1:0]  instr_rd, instr_rs1, instr_rs2;
    logic [DATA_W-1:0] instr_imm;
    logic [DATA_W-1:0] alu_a, alu_b, alu_out;
    logic [DATA_W-1:0] alu_a2, alu_b2, alu_out2;
    logic [2:0]        alu_opcode, alu_opcode2;
    logic              res_valid, res_valid2;
    logic [REG_W-1:0]  res_rd, res_rd2;
    logic [DATA_W-1:0] res_data, res_data2;
    logic [REG_W-1:0]  dbg_addr;
    logic [DATA_W-1:0] dbg_data, dbg_data2;
    logic [15:0]       retired;
    logic [1:0]        retired2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = a * b;
        case (op)
            OP_INV:  return ~a;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_AND:  return a & b;
            OP_MUL:  return prod[7:0];
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_out  = alu_model(alu_opcode, alu_a, alu_b);
    assign alu_out2 = alu_model(alu_opcode2, alu_a2, alu_b2);

    alu_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .instr_imm(instr_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .retired(retired)
    );

    alu_sequencer #(.CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready2),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .instr_imm(instr_imm), .alu_a(alu_a2), .alu_b(alu_b2), .alu_opcode(alu_opcode2),
        .alu_out(alu_out2), .res_valid(res_valid2), .res_rd(res_rd2), .res_data(res_data2),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data2), .retired(retired2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic run_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                             input logic [1:0] rs2, input logic [7:0] imm, input logic [7:0] exp);
        int waited;
        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
        instr_valid = 1'b1;
        waited = 0;
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) chk("accept_timeout", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        if (res_valid || instr_ready) chk("exec_state", {res_valid, instr_ready}, 2'b00);
        @(negedge clk);
        chk("wb_valid", 32'(res_valid), 32'd1);
        chk("wb_rd", 32'(res_rd), 32'(rd));
        chk("wb_data", 32'(res_data), 32'(exp));
        @(negedge clk);
        if (res_valid || !instr_ready) chk("wb_pulse_1cyc", {res_valid, instr_ready}, 2'b01);
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        dbg_addr = addr;
        #1 chk(tag, 32'(dbg_data), 32'(exp));
    endtask

    initial begin
        int readies;
        rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0;
        instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0; dbg_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk_reg("rst_r0", 2'd0, 8'h00);

        run_instr(OP_LDI, 2'd0, 2'd0, 2'd0, 8'd5, 8'd5);
        run_instr(OP_LDI, 2'd1, 2'd0, 2'd0, 8'd3, 8'd3);
        run_instr(OP_ADD, 2'd2, 2'd0, 2'd1, 8'hAA, 8'd8);
        chk_reg("add_r2", 2'd2, 8'd8);
        chk("retired_3", 32'(retired), 32'd3);
        run_instr(OP_SUB, 2'd3, 2'd1, 2'd0, 8'h00, 8'hFE);
        run_instr(OP_INV, 2'd0, 2'd0, 2'd0, 8'h00, 8'hFA);
        chk("retired_w2_wrap", 32'(retired2), 32'd1);

        run_instr(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h10, 8'h10);
        run_instr(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h10, 8'h10);
        run_instr(OP_MUL, 2'd2, 2'd0, 2'd1, 8'h00, 8'h00);
        run_instr(OP_LDI, 2'd0, 2'd0, 2'd0, 8'hF0, 8'hF0);
        run_instr(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h3C, 8'h3C);
        run_instr(OP_AND, 2'd2, 2'd0, 2'd1, 8'h00, 8'h30);
        run_instr(OP_OR,  2'd3, 2'd0, 2'd1, 8'h00, 8'hFC);
        run_instr(OP_XOR, 2'd2, 2'd0, 2'd1, 8'h00, 8'hCC);
        chk_reg("xor_r2", 2'd2, 8'hCC);
        chk_reg("or_r3", 2'd3, 8'hFC);

        run_instr(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h01, 8'h01);
        run_instr(OP_ADD, 2'd0, 2'd0, 2'd0, 8'h00, 8'h02);
        run_instr(OP_ADD, 2'd0, 2'd0, 2'd0, 8'h00, 8'h04);
        run_instr(OP_ADD, 2'd0, 2'd0, 2'd0, 8'h00, 8'h08);
        run_instr(OP_ADD, 2'd0, 2'd0, 2'd0, 8'h00, 8'h10);
        chk_reg("chain_r0", 2'd0, 8'h10);
        chk("retired_18", 32'(retired), 32'd18);

        // Continuous valid: r3 = r0 + r1 = 0x10 + 0x3C.
        instr_op = OP_ADD; instr_rd = 2'd3; instr_rs1 = 2'd0; instr_rs2 = 2'd1; instr_imm = 8'h00;
        instr_valid = 1'b1;
        readies = 0;
        for (int c = 0; c < 9; c++) begin
            if (instr_ready) readies++;
            if (c % 3 == 1) begin
                chk("bp_exec_a", 32'(alu_a), 32'h10);
                chk("bp_exec_b", 32'(alu_b), 32'h3C);
                chk("bp_exec_ready", 32'(instr_ready), 32'd0);
            end
            if (c % 3 == 2) chk("bp_wb_ready", 32'(instr_ready), 32'd0);
            if (c < 8) @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("bp_accepts", 32'(readies), 32'd3);
        @(negedge clk);
        chk_reg("bp_r3", 2'd3, 8'h4C);
        chk("retired_21", 32'(retired), 32'd21);

        // Reset during EXEC of r2 = r0 + r1.
        instr_op = OP_ADD; instr_rd = 2'd2; instr_rs1 = 2'd0; instr_rs2 = 2'd1;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", 32'(instr_ready), 32'd1);
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_outs", {alu_a, alu_b, 5'(alu_opcode), 6'(res_rd)}, 32'd0);
        chk("mid_rst_data", 32'(res_data), 32'd0);
        chk("mid_rst_retired", 32'(retired), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (res_valid) chk("mid_rst_no_wb", 32'(res_valid), 32'd0);
        end
        chk_reg("mid_rst_r2", 2'd2, 8'h00);
        chk_reg("mid_rst_r0", 2'd0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
